// File: rtl/rx_packer_fifo.sv
// Receive-path packer FIFO: captures channel sample sets into a circular buffer, tags window starts,
// and serves bursts to the host. Optional macro TAG_COUNT_EN adds a window counter to the tag words.
module rx_packer_fifo #(
    parameter int            DW        = 16,
    parameter int            MAX_CH    = 8,
    parameter int            ADDR_W    = 12,
    parameter int            PKT_WORDS = 256,
    parameter logic [DW-1:0] DATA_TAG  = DW'(16'h4000)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 gate_enable,
    input  logic                 strobe,
    input  logic [3:0]           channels,
    input  logic [MAX_CH*DW-1:0] din,
    input  logic                 rd_req,
    output logic [DW-1:0]        dout,
    output logic                 rd_valid,
    output logic                 packet_rdy,
    output logic [ADDR_W:0]      level,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clear_status
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LW    = ADDR_W + 1;
    localparam int BW    = $clog2(PKT_WORDS + 1);
    localparam int CW    = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [3:0]                    ch_eff_q, ch_eff_d, ch_eff;
    logic [MAX_CH-1:0][DW-1:0]     set_q, set_d;
    logic                          gate_q;
    logic                          armed_q, armed_d;
    logic [ADDR_W-1:0]             wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]                 level_q, level_d, free;
    logic [BW-1:0]                 burst_q, burst_d;
    logic [DW-1:0]                 dout_q;
    logic                          rd_valid_q;
    logic                          ovf_q, udf_q;
    logic                          we, pop, drop, empty, rd_ok, tag_now, tag_accept;
    logic [DW-1:0]                 tag_word;
    logic [DW-1:0]                 mem [DEPTH];

`ifdef TAG_COUNT_EN
    logic [7:0] win_q;
    assign tag_word = {DATA_TAG[DW-1:8], win_q};
`else
    assign tag_word = DATA_TAG;
`endif

    always_comb begin
        if (channels == 4'd0)
            ch_eff = 4'd1;
        else if (32'(channels) > MAX_CH)
            ch_eff = 4'(MAX_CH);
        else
            ch_eff = channels;
    end

    // A strobe landing on the very cycle the gate rises still counts as the window's first set.
    assign tag_now = armed_q | (gate_enable & ~gate_q);
    assign free    = LW'(DEPTH) - level_q;
    assign empty   = (level_q == '0);
    assign rd_ok   = rd_req & (burst_q < BW'(PKT_WORDS));
    assign pop     = rd_ok & ~empty;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_eff_d   = ch_eff_q;
        set_d      = set_q;
        armed_d    = tag_now;
        we         = 1'b0;
        drop       = 1'b0;
        tag_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe & gate_enable) begin
                    if (free >= LW'(ch_eff)) begin
                        set_d      = tag_now ? {MAX_CH{tag_word}} : din;
                        ch_eff_d   = ch_eff;
                        cnt_d      = '0;
                        state_d    = WRITE;
                        armed_d    = 1'b0;
                        tag_accept = tag_now;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            WRITE: begin
                we    = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ch_eff_q - 4'd1))
                    state_d = IDLE;
                if (strobe & gate_enable)
                    drop = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign level_d = level_q + LW'(we) - LW'(pop);
    assign burst_d = rd_req ? burst_q + BW'(pop) : '0;

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_ptr_q] <= set_q[cnt_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ch_eff_q   <= '0;
            set_q      <= '0;
            gate_q     <= 1'b0;
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            burst_q    <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_eff_q   <= ch_eff_d;
            set_q      <= set_d;
            gate_q     <= gate_enable;
            armed_q    <= armed_d;
            level_q    <= level_d;
            burst_q    <= burst_d;
            rd_valid_q <= pop;
            if (we)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                dout_q   <= mem[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            ovf_q <= drop | (ovf_q & ~clear_status);
            udf_q <= (rd_ok & empty) | (udf_q & ~clear_status);
        end
    end

`ifdef TAG_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            win_q <= '0;
        else if (tag_accept)
            win_q <= win_q + 8'd1;
    end
`endif

    assign dout       = dout_q;
    assign rd_valid   = rd_valid_q;
    assign level      = level_q;
    assign packet_rdy = (level_q >= LW'(PKT_WORDS));
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: tb/tb_rx_packer_fifo.sv
// Scoreboard bench for rx_packer_fifo: stimulus pushes expected words, a negedge monitor pops and compares.
// Honours TAG_COUNT_EN when modelling tag words.
module tb_rx_packer_fifo;

    localparam int DW     = 16;
    localparam int MAX_CH = 8;
    localparam int ADDR_W = 12;
    localparam int PKT    = 256;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                 clk;
    logic                 reset_n;
    logic                 gate_enable;
    logic                 strobe;
    logic [3:0]           channels;
    logic [MAX_CH*DW-1:0] din;
    logic                 rd_req;
    logic [DW-1:0]        dout;
    logic                 rd_valid;
    logic                 packet_rdy;
    logic [ADDR_W:0]      level;
    logic                 overflow;
    logic                 underflow;
    logic                 clear_status;

    int            nCompared = 0;
    int            nMismatched = 0;
    int            validCount = 0;
    int            tbLevel = 0;
    int            seq = 1;
    bit            tbArmed = 0;
    logic [7:0]    tbWin = 8'd0;
    logic [DW-1:0] sb [$];
    bit            dropped;

    rx_packer_fifo #(
        .DW(DW), .MAX_CH(MAX_CH), .ADDR_W(ADDR_W), .PKT_WORDS(PKT), .DATA_TAG(16'h4000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .gate_enable(gate_enable), .strobe(strobe),
        .channels(channels), .din(din), .rd_req(rd_req), .dout(dout), .rd_valid(rd_valid),
        .packet_rdy(packet_rdy), .level(level), .overflow(overflow), .underflow(underflow),
        .clear_status(clear_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            validCount++;
            if (sb.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL rd_data: got 0x%0h, expected no word (queue empty)", dout);
            end else begin
                checkOutput("rd_data", 32'(dout), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] tagWord();
        logic [DW-1:0] t;
        t = 16'h4000;
`ifdef TAG_COUNT_EN
        t[7:0] = tbWin;
`endif
        return t;
    endfunction

    function automatic logic [MAX_CH*DW-1:0] makeDin();
        logic [MAX_CH*DW-1:0] d;
        for (int i = 0; i < MAX_CH; i++) begin
            d[i*DW +: DW] = DW'(seq);
            seq++;
        end
        return d;
    endfunction

    // One sample set; with collide the strobe is held into the first WRITE cycle.
    task automatic applyStimulus(input logic [3:0] ch, input logic [MAX_CH*DW-1:0] d,
                                 input bit collide, output bit drp);
        int chEff;
        logic [DW-1:0] tw;
        chEff = (ch == 4'd0) ? 1 : ((int'(ch) > MAX_CH) ? MAX_CH : int'(ch));
        drp = (tbLevel + chEff > DEPTH);
        if (!drp) begin
            tw = tagWord();
            for (int i = 0; i < chEff; i++)
                sb.push_back(tbArmed ? tw : d[i*DW +: DW]);
            if (tbArmed) begin
                tbArmed = 0;
                tbWin++;
            end
            tbLevel += chEff;
        end
        channels = ch;
        din      = d;
        strobe   = 1'b1;
        tick();
        if (collide)
            tick();
        strobe = 1'b0;
        repeat (chEff) tick();
    endtask

    task automatic readBurst(input int n);
        int pops;
        pops = n;
        if (pops > PKT) pops = PKT;
        if (pops > tbLevel) pops = tbLevel;
        rd_req = 1'b1;
        repeat (n) tick();
        rd_req = 1'b0;
        tick();
        tbLevel -= pops;
    endtask

    task automatic fillTo(input int target);
        bit drp;
        while (tbLevel + MAX_CH <= target)
            applyStimulus(4'(MAX_CH), makeDin(), 1'b0, drp);
        if (target > tbLevel)
            applyStimulus(4'(target - tbLevel), makeDin(), 1'b0, drp);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_level"}, 32'(level), 32'd0);
        checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, "_dout"}, 32'(dout), 32'd0);
        checkOutput({tag, "_packet_rdy"}, 32'(packet_rdy), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_underflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        logic [MAX_CH*DW-1:0] d;
        reset_n = 1'b0; gate_enable = 1'b0; strobe = 1'b0; channels = 4'd0;
        din = '0; rd_req = 1'b0; clear_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        reset_n = 1'b1;
        tick();

        // Window 1: tag set followed by two data sets of two channels.
        gate_enable = 1'b1;
        tick();
        tbArmed = 1;
        d = '0;
        d[15:0]  = 16'h0011;
        d[31:16] = 16'h0022;
        repeat (3) applyStimulus(4'd2, d, 1'b0, dropped);
        checkOutput("level_after_3_sets", 32'(level), 32'd6);
        readBurst(8);
        checkOutput("words_read_w1", 32'(validCount), 32'd6);
        checkOutput("underflow_on_empty", 32'(underflow), 32'd1);
        checkOutput("rd_valid_idle", 32'(rd_valid), 32'd0);
        checkOutput("level_drained_w1", 32'(level), 32'd0);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        checkOutput("underflow_cleared", 32'(underflow), 32'd0);

        // Window 2: channel count clamping and a collision drop.
        gate_enable = 1'b0;
        tick();
        gate_enable = 1'b1;
        tick();
        tbArmed = 1;
        d = '0;
        d[15:0] = 16'hABCD;
        applyStimulus(4'd0, d, 1'b0, dropped);
        applyStimulus(4'd0, d, 1'b0, dropped);
        for (int i = 0; i < MAX_CH; i++)
            d[i*DW +: DW] = DW'(16'h1000 + i);
        applyStimulus(4'd12, d, 1'b0, dropped);
        checkOutput("level_clamped_sets", 32'(level), 32'd10);
        applyStimulus(4'd8, makeDin(), 1'b1, dropped);
        checkOutput("overflow_collision", 32'(overflow), 32'd1);
        checkOutput("level_after_collision", 32'(level), 32'd18);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        checkOutput("overflow_cleared", 32'(overflow), 32'd0);
        readBurst(30);
        checkOutput("words_read_w2", 32'(validCount), 32'd24);
        checkOutput("scoreboard_empty_w2", 32'(sb.size()), 32'd0);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;

        // Burst limit: 600 words, request held 300 cycles twice.
        fillTo(600);
        checkOutput("level_600", 32'(level), 32'd600);
        checkOutput("packet_rdy_600", 32'(packet_rdy), 32'd1);
        validCount = 0;
        rd_req = 1'b1;
        checkOutput("rd_valid_before_pop", 32'(rd_valid), 32'd0);
        tick();
        checkOutput("rd_valid_latency", 32'(rd_valid), 32'd1);
        repeat (299) tick();
        checkOutput("burst1_pops", 32'(validCount), 32'd256);
        checkOutput("underflow_burst_limit", 32'(underflow), 32'd0);
        rd_req = 1'b0;
        tick();
        tbLevel -= PKT;
        checkOutput("level_344", 32'(level), 32'd344);
        readBurst(300);
        checkOutput("burst2_pops", 32'(validCount), 32'd512);
        checkOutput("level_88", 32'(level), 32'd88);
        checkOutput("packet_rdy_88", 32'(packet_rdy), 32'd0);

        // Near-full: drop when free < ch_eff, clear loses to a same-cycle drop.
        fillTo(DEPTH - 3);
        checkOutput("level_depth_m3", 32'(level), 32'(DEPTH - 3));
        checkOutput("overflow_before_drop", 32'(overflow), 32'd0);
        applyStimulus(4'd4, makeDin(), 1'b0, dropped);
        checkOutput("overflow_full_drop", 32'(overflow), 32'd1);
        checkOutput("level_unchanged_drop", 32'(level), 32'(DEPTH - 3));
        channels = 4'd4;
        strobe = 1'b1;
        clear_status = 1'b1;
        tick();
        strobe = 1'b0;
        clear_status = 1'b0;
        checkOutput("overflow_set_beats_clear", 32'(overflow), 32'd1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        checkOutput("overflow_clear_alone", 32'(overflow), 32'd0);
        applyStimulus(4'd3, makeDin(), 1'b0, dropped);
        checkOutput("level_full", 32'(level), 32'(DEPTH));
        checkOutput("overflow_exact_fit", 32'(overflow), 32'd0);
        validCount = 0;
        repeat (DEPTH / PKT) readBurst(PKT + 1);
        checkOutput("full_drain_pops", 32'(validCount), 32'(DEPTH));
        checkOutput("scoreboard_empty_full", 32'(sb.size()), 32'd0);
        checkOutput("level_after_drain", 32'(level), 32'd0);
        checkOutput("underflow_exact_burst", 32'(underflow), 32'd0);

        // Reset in the middle of a 4-channel write.
        gate_enable = 1'b0;
        tick();
        gate_enable = 1'b1;
        tick();
        channels = 4'd4;
        din = makeDin();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        gate_enable = 1'b0;
        reset_n = 1'b0;
        #1;
        checkReset("mid_write_reset");
        tick();
        reset_n = 1'b1;
        tbArmed = 0;
        tbWin = 8'd0;
        tbLevel = 0;
        tick();
        gate_enable = 1'b1;
        tick();
        tbArmed = 1;
        d = '0;
        d[15:0] = 16'h5555;
        applyStimulus(4'd1, d, 1'b0, dropped);
        applyStimulus(4'd1, d, 1'b0, dropped);
        checkOutput("level_after_reset_sets", 32'(level), 32'd2);
        validCount = 0;
        readBurst(2);
        checkOutput("post_reset_pops", 32'(validCount), 32'd2);
        checkOutput("scoreboard_empty_end", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
